// File: rtl/bridge_pkg.sv
// Shared definitions for the AHB-to-APB bridge: state encoding, default widths
// and the one-hot select codes of the three APB peripherals.
package bridge_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam int SEL_W_DEF  = 3;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_WWAIT    = 3'd1;
  localparam logic [2:0] ST_READ     = 3'd2;
  localparam logic [2:0] ST_RENABLE  = 3'd3;
  localparam logic [2:0] ST_WRITE    = 3'd4;
  localparam logic [2:0] ST_WRITEP   = 3'd5;
  localparam logic [2:0] ST_WENABLE  = 3'd6;
  localparam logic [2:0] ST_WENABLEP = 3'd7;

  localparam logic [2:0] SEL_P0 = 3'b001;
  localparam logic [2:0] SEL_P1 = 3'b010;
  localparam logic [2:0] SEL_P2 = 3'b100;

endpackage

// File: rtl/apb_fsm_controller.sv
// Bridge control FSM: turns pipelined AHB transfers into registered APB
// SETUP/ENABLE phases and stalls the AHB master through Hreadyout.
//
// state       | meaning
// ST_IDLE     | no APB transfer, bus released
// ST_WWAIT    | write address seen, waiting one cycle for its data
// ST_READ     | read SETUP phase, master stalled
// ST_RENABLE  | read ENABLE phase
// ST_WRITE    | write SETUP phase, nothing queued behind it
// ST_WRITEP   | write SETUP phase with a pipelined transfer pending (stall)
// ST_WENABLE  | write ENABLE phase, nothing queued
// ST_WENABLEP | write ENABLE phase with a pipelined transfer pending
module apb_fsm_controller
  import bridge_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int SEL_W  = SEL_W_DEF
) (
  input  logic              Hclk,
  input  logic              Hresetn,
  input  logic              valid,
  input  logic [ADDR_W-1:0] Haddr,
  input  logic [ADDR_W-1:0] Haddr1,
  input  logic [ADDR_W-1:0] Haddr2,
  input  logic [DATA_W-1:0] Hwdata,
  input  logic [DATA_W-1:0] Hwdata1,
  input  logic              Hwrite,
  input  logic              Hwritereg,
  input  logic [SEL_W-1:0]  tempselx,
  output logic              Pwrite,
  output logic [SEL_W-1:0]  Pselx,
  output logic              Penable,
  output logic [ADDR_W-1:0] Paddr,
  output logic [DATA_W-1:0] Pwdata,
  output logic              Hreadyout
);

  logic [2:0]        state, next_state;
  logic              n_pwrite, n_penable, n_hready;
  logic [SEL_W-1:0]  n_pselx;
  logic [ADDR_W-1:0] n_paddr;
  logic [DATA_W-1:0] n_pwdata;

  always_comb begin
    next_state = ST_IDLE;
    case (state)
      ST_IDLE: begin
        if (valid && Hwrite)      next_state = ST_WWAIT;
        else if (valid)           next_state = ST_READ;
        else                      next_state = ST_IDLE;
      end
      ST_WWAIT:    next_state = valid ? ST_WRITEP : ST_WRITE;
      ST_READ:     next_state = ST_RENABLE;
      ST_WRITE:    next_state = valid ? ST_WENABLEP : ST_WENABLE;
      ST_WRITEP:   next_state = ST_WENABLEP;
      ST_RENABLE, ST_WENABLE: begin
        if (valid && !Hwrite)     next_state = ST_READ;
        else if (valid)           next_state = ST_WWAIT;
        else                      next_state = ST_IDLE;
      end
      ST_WENABLEP: begin
        if (!Hwritereg)           next_state = ST_READ;
        else if (valid)           next_state = ST_WRITEP;
        else                      next_state = ST_WRITE;
      end
      default:     next_state = ST_IDLE;
    endcase
  end

  // Outputs are computed for the state being entered so they line up with it.
  always_comb begin
    n_pwrite  = Pwrite;
    n_pselx   = Pselx;
    n_penable = Penable;
    n_paddr   = Paddr;
    n_pwdata  = Pwdata;
    n_hready  = Hreadyout;
    case (next_state)
      ST_IDLE: begin
        n_pselx   = '0;
        n_penable = 1'b0;
        n_pwrite  = 1'b0;
        n_hready  = 1'b1;
      end
      ST_WWAIT: begin
        n_pselx   = '0;
        n_penable = 1'b0;
        n_hready  = 1'b1;
      end
      ST_READ: begin
        n_paddr   = Haddr;
        n_pwrite  = 1'b0;
        n_pselx   = tempselx;
        n_penable = 1'b0;
        n_hready  = 1'b0;
      end
      ST_WRITE, ST_WRITEP: begin
        // From WENABLEP the transfer being issued is one pipeline stage older.
        if (state == ST_WENABLEP) begin
          n_paddr  = Haddr2;
          n_pwdata = Hwdata1;
        end else begin
          n_paddr  = Haddr1;
          n_pwdata = Hwdata;
        end
        n_pwrite  = 1'b1;
        n_pselx   = tempselx;
        n_penable = 1'b0;
        n_hready  = (next_state == ST_WRITE);
      end
      ST_RENABLE, ST_WENABLE, ST_WENABLEP: begin
        n_penable = 1'b1;
        n_hready  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Hclk) begin
    if (!Hresetn) begin
      state     <= ST_IDLE;
      Pwrite    <= 1'b0;
      Pselx     <= '0;
      Penable   <= 1'b0;
      Paddr     <= '0;
      Pwdata    <= '0;
      Hreadyout <= 1'b1;
    end else begin
      state     <= next_state;
      Pwrite    <= n_pwrite;
      Pselx     <= n_pselx;
      Penable   <= n_penable;
      Paddr     <= n_paddr;
      Pwdata    <= n_pwdata;
      Hreadyout <= n_hready;
    end
  end

endmodule

// File: tb/tb_apb_fsm_controller.sv
// Directed bench for apb_fsm_controller: the driver queues the expected APB
// outputs for every cycle it drives; a monitor pops and compares after each edge.
module tb_apb_fsm_controller;
  import bridge_pkg::*;

  logic        Hclk = 1'b0;
  logic        Hresetn = 1'b0;
  logic        valid = 1'b0;
  logic [31:0] Haddr = '0, Haddr1 = '0, Haddr2 = '0;
  logic [31:0] Hwdata = '0, Hwdata1 = '0;
  logic        Hwrite = 1'b0, Hwritereg = 1'b0;
  logic [2:0]  tempselx = '0;
  logic        Pwrite, Penable, Hreadyout;
  logic [2:0]  Pselx;
  logic [31:0] Paddr, Pwdata;

  apb_fsm_controller dut (
    .Hclk(Hclk), .Hresetn(Hresetn), .valid(valid),
    .Haddr(Haddr), .Haddr1(Haddr1), .Haddr2(Haddr2),
    .Hwdata(Hwdata), .Hwdata1(Hwdata1), .Hwrite(Hwrite), .Hwritereg(Hwritereg),
    .tempselx(tempselx), .Pwrite(Pwrite), .Pselx(Pselx), .Penable(Penable),
    .Paddr(Paddr), .Pwdata(Pwdata), .Hreadyout(Hreadyout)
  );

  always #5 Hclk = ~Hclk;

  typedef struct {
    string       name;
    logic        pwrite;
    logic [2:0]  pselx;
    logic        penable;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic        hready;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic step(input string nm, input logic r, input logic v, input logic w,
                      input logic wreg, input logic [31:0] a, input logic [31:0] a1,
                      input logic [31:0] a2, input logic [31:0] d, input logic [31:0] d1,
                      input logic [2:0] s, input logic ew, input logic [2:0] es,
                      input logic ee, input logic [31:0] ea, input logic [31:0] ed,
                      input logic eh);
    exp_t e;
    @(negedge Hclk);
    Hresetn = r; valid = v; Hwrite = w; Hwritereg = wreg;
    Haddr = a; Haddr1 = a1; Haddr2 = a2; Hwdata = d; Hwdata1 = d1; tempselx = s;
    e.name = nm; e.pwrite = ew; e.pselx = es; e.penable = ee;
    e.paddr = ea; e.pwdata = ed; e.hready = eh;
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge Hclk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (Pwrite !== e.pwrite || Pselx !== e.pselx || Penable !== e.penable ||
            Paddr !== e.paddr || Pwdata !== e.pwdata || Hreadyout !== e.hready) begin
          n_fail++;
          $display("FAIL %s: got pwrite=%b pselx=%b penable=%b paddr=%h pwdata=%h hready=%b, expected pwrite=%b pselx=%b penable=%b paddr=%h pwdata=%h hready=%b",
                   e.name, Pwrite, Pselx, Penable, Paddr, Pwdata, Hreadyout,
                   e.pwrite, e.pselx, e.penable, e.paddr, e.pwdata, e.hready);
        end
        n_checks++;
        if (Penable === 1'b1 && Pselx === 3'b000) begin
          n_fail++;
          $display("FAIL phase_rule %s: penable=%b with pselx=%b, required pselx nonzero",
                   e.name, Penable, Pselx);
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

  localparam logic [31:0] A0 = 32'h8400_0100, A1 = 32'h8400_0104, A2 = 32'h8400_0108;
  localparam logic [31:0] D0 = 32'h1111_1111, D1 = 32'h2222_2222, D2 = 32'h3333_3333;
  localparam logic [31:0] DECOY = 32'hBAD0_BAD0;

  initial begin : driver
    //          name            r  v  w  wr haddr          haddr1         haddr2         hwdata         hwdata1  sel     | pw psel    pen paddr          pwdata         hr
    step("reset0",        0, 1, 0, 0, 32'h0000_1234, '0,            '0,            '0,            '0,  SEL_P0, 0, 3'b000, 0, 32'h0,          32'h0,         1);
    step("reset1",        0, 1, 0, 0, 32'h0000_1234, '0,            '0,            '0,            '0,  SEL_P0, 0, 3'b000, 0, 32'h0,          32'h0,         1);
    // single read; tempselx changes during ENABLE must be ignored
    step("rd_setup",      1, 1, 0, 0, 32'h8000_0010, '0,            '0,            '0,            '0,  SEL_P0, 0, SEL_P0, 0, 32'h8000_0010,  32'h0,         0);
    step("rd_enable",     1, 0, 0, 0, 32'h0,         '0,            '0,            '0,            '0,  SEL_P2, 0, SEL_P0, 1, 32'h8000_0010,  32'h0,         1);
    step("rd_idle",       1, 0, 0, 0, 32'h0,         '0,            '0,            '0,            '0,  SEL_P2, 0, 3'b000, 0, 32'h8000_0010,  32'h0,         1);
    // single write
    step("wr_wwait",      1, 1, 1, 0, 32'h8400_0004, '0,            '0,            '0,            '0,  SEL_P1, 0, 3'b000, 0, 32'h8000_0010,  32'h0,         1);
    step("wr_setup",      1, 0, 0, 1, 32'h0,         32'h8400_0004, '0,            32'hDEAD_BEEF, '0,  SEL_P1, 1, SEL_P1, 0, 32'h8400_0004,  32'hDEAD_BEEF, 1);
    step("wr_enable",     1, 0, 0, 0, 32'h0,         '0,            '0,            '0,            '0,  SEL_P1, 1, SEL_P1, 1, 32'h8400_0004,  32'hDEAD_BEEF, 1);
    step("wr_idle",       1, 0, 0, 0, 32'h0,         '0,            '0,            '0,            '0,  SEL_P1, 0, 3'b000, 0, 32'h8400_0004,  32'hDEAD_BEEF, 1);
    // burst of three writes with valid held high
    step("bw_wwait",      1, 1, 1, 0, A0,            '0,            '0,            '0,            '0,  SEL_P1, 0, 3'b000, 0, 32'h8400_0004,  32'hDEAD_BEEF, 1);
    step("bw_setup0",     1, 1, 1, 1, A1,            A0,            '0,            D0,            '0,  SEL_P1, 1, SEL_P1, 0, A0,             D0,            0);
    step("bw_enable0",    1, 1, 1, 1, A1,            A1,            A0,            D1,            D0,  SEL_P1, 1, SEL_P1, 1, A0,             D0,            1);
    step("bw_setup1",     1, 1, 1, 1, A2,            A1,            A1,            D2,            D1,  SEL_P1, 1, SEL_P1, 0, A1,             D1,            0);
    step("bw_enable1",    1, 1, 1, 1, A2,            A2,            A1,            D2,            D1,  SEL_P1, 1, SEL_P1, 1, A1,             D1,            1);
    step("bw_setup2",     1, 0, 0, 1, 32'h8400_0FFC, 32'h8400_0FFC, A2,            DECOY,         D2,  SEL_P1, 1, SEL_P1, 0, A2,             D2,            1);
    step("bw_enable2",    1, 0, 0, 0, 32'h0,         '0,            '0,            '0,            '0,  SEL_P1, 1, SEL_P1, 1, A2,             D2,            1);
    step("bw_idle",       1, 0, 0, 0, 32'h0,         '0,            '0,            '0,            '0,  SEL_P1, 0, 3'b000, 0, A2,             D2,            1);
    // write followed by read: READ uses the live address
    step("wr2_wwait",     1, 1, 1, 0, 32'h8400_0200, '0,            '0,            '0,            '0,  SEL_P1, 0, 3'b000, 0, A2,             D2,            1);
    step("wr2_setup",     1, 1, 0, 1, 32'h8800_0020, 32'h8400_0200, '0,            32'h5555_AAAA, '0,  SEL_P2, 1, SEL_P2, 0, 32'h8400_0200,  32'h5555_AAAA, 0);
    step("wr2_enable",    1, 1, 0, 0, 32'h8800_0020, 32'h8800_0020, 32'h8400_0200, DECOY,        DECOY, SEL_P2, 1, SEL_P2, 1, 32'h8400_0200,  32'h5555_AAAA, 1);
    step("wr2rd_setup",   1, 1, 0, 0, 32'h8800_0020, 32'h8800_0020, 32'h8400_0300, DECOY,        DECOY, SEL_P2, 0, SEL_P2, 0, 32'h8800_0020,  32'h5555_AAAA, 0);
    step("wr2rd_enable",  1, 0, 0, 0, 32'h0,         '0,            '0,            '0,            '0,  SEL_P0, 0, SEL_P2, 1, 32'h8800_0020,  32'h5555_AAAA, 1);
    step("wr2rd_idle",    1, 0, 0, 0, 32'h0,         '0,            '0,            '0,            '0,  SEL_P0, 0, 3'b000, 0, 32'h8800_0020,  32'h5555_AAAA, 1);
    // reset while in RENABLE, then reads resume (incl. back-to-back from RENABLE)
    step("rr_setup",      1, 1, 0, 0, 32'h8000_0040, '0,            '0,            '0,            '0,  SEL_P0, 0, SEL_P0, 0, 32'h8000_0040,  32'h5555_AAAA, 0);
    step("rr_enable",     1, 0, 0, 0, 32'h0,         '0,            '0,            '0,            '0,  SEL_P0, 0, SEL_P0, 1, 32'h8000_0040,  32'h5555_AAAA, 1);
    step("rr_reset",      0, 1, 0, 0, 32'h8000_0044, '0,            '0,            '0,            '0,  SEL_P0, 0, 3'b000, 0, 32'h0,          32'h0,         1);
    step("rr_post_setup", 1, 1, 0, 0, 32'h8000_0050, '0,            '0,            '0,            '0,  SEL_P0, 0, SEL_P0, 0, 32'h8000_0050,  32'h0,         0);
    step("rr_post_enable",1, 0, 0, 0, 32'h0,         '0,            '0,            '0,            '0,  SEL_P0, 0, SEL_P0, 1, 32'h8000_0050,  32'h0,         1);
    step("rr_b2b_setup",  1, 1, 0, 0, 32'h8000_0060, '0,            '0,            '0,            '0,  SEL_P2, 0, SEL_P2, 0, 32'h8000_0060,  32'h0,         0);
    step("rr_b2b_enable", 1, 0, 0, 0, 32'h0,         '0,            '0,            '0,            '0,  SEL_P1, 0, SEL_P2, 1, 32'h8000_0060,  32'h0,         1);
    step("final_idle",    1, 0, 0, 0, 32'h0,         '0,            '0,            '0,            '0,  SEL_P1, 0, 3'b000, 0, 32'h8000_0060,  32'h0,         1);

    repeat (3) @(negedge Hclk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
